// File: rtl/ap_mult_err_mon.sv
// ap_mult_err_mon: error-statistics monitor for an approximate DW x DW
// unsigned multiplier. The block takes one sample per cycle, recomputes the
// exact product, and accumulates over a run of `len` samples:
//   - the error count,
//   - the sum of error distances,
//   - the maximum error distance and the operands that first produced it.
//
// Handshake: a sample transfers on a rising clk edge when in_vld & in_rdy.
// in_rdy is high only in RUN, and inputs are ignored while it is low.
// in_vld may drop at any time to leave bubbles.
module ap_mult_err_mon #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      len,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DW-1:0]         muld,
    input  logic [DW-1:0]         mulr,
    input  logic [2*DW-1:0]       res,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [2*DW+CNT_W-1:0] sum_ed,
    output logic [2*DW-1:0]       max_ed,
    output logic [DW-1:0]         max_muld,
    output logic [DW-1:0]         max_mulr,
    output logic [1:0]            dbg_state
);

    localparam int PW = 2 * DW;
    localparam int SW = 2 * DW + CNT_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             drain_q, drain_d;
    logic             in_rdy_q, busy_q, done_q;
    logic             clr_stats;
    logic             xfer;

    // Stage 1: captured sample plus exact product
    logic          s1_vld_q;
    logic [DW-1:0] s1_muld_q, s1_mulr_q;
    logic [PW-1:0] s1_res_q, s1_exact_q;

    // Stage 2: absolute error distance
    logic          s2_vld_q;
    logic          s2_err_q;
    logic [PW-1:0] s2_ed_q;
    logic [DW-1:0] s2_muld_q, s2_mulr_q;
    logic [PW-1:0] ed_d;

    // Statistics
    logic [CNT_W-1:0] err_cnt_q;
    logic [SW-1:0]    sum_ed_q;
    logic [PW-1:0]    max_ed_q;
    logic [DW-1:0]    max_muld_q, max_mulr_q;

    assign xfer = in_vld & in_rdy_q;

    // Next-state logic for the run controller
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        drain_d   = drain_q;
        clr_stats = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clr_stats = 1'b1;
                    if (len != '0) begin
                        state_d = ST_RUN;
                        rem_d   = len;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    rem_d = rem_q - CNT_ONE;
                    if (rem_q == CNT_ONE) begin
                        state_d = ST_DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            // Two cycles let the last sample travel S1 -> S2 -> statistics,
            // so the final update lands on the same edge that enters DONE.
            ST_DRAIN: begin
                if (drain_q) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Run controller state and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            drain_q  <= 1'b0;
            in_rdy_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            drain_q  <= drain_d;
            in_rdy_q <= (state_d == ST_RUN);
            busy_q   <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            done_q   <= (state_d == ST_DONE);
        end
    end

    // Stage 1: register the accepted sample and its exact product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_muld_q  <= '0;
            s1_mulr_q  <= '0;
            s1_res_q   <= '0;
            s1_exact_q <= '0;
        end else begin
            s1_vld_q <= xfer;
            if (xfer) begin
                s1_muld_q  <= muld;
                s1_mulr_q  <= mulr;
                s1_res_q   <= res;
                s1_exact_q <= PW'(muld) * PW'(mulr);
            end
        end
    end

    // Absolute difference, so overestimates count as errors as well
    assign ed_d = (s1_exact_q >= s1_res_q) ? (s1_exact_q - s1_res_q)
                                           : (s1_res_q - s1_exact_q);

    // Stage 2: register error distance and error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld_q  <= 1'b0;
            s2_err_q  <= 1'b0;
            s2_ed_q   <= '0;
            s2_muld_q <= '0;
            s2_mulr_q <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_err_q  <= (ed_d != '0);
                s2_ed_q   <= ed_d;
                s2_muld_q <= s1_muld_q;
                s2_mulr_q <= s1_mulr_q;
            end
        end
    end

    // Stage 3: accumulate statistics; strict compare keeps the earliest max
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q  <= '0;
            sum_ed_q   <= '0;
            max_ed_q   <= '0;
            max_muld_q <= '0;
            max_mulr_q <= '0;
        end else if (clr_stats) begin
            err_cnt_q  <= '0;
            sum_ed_q   <= '0;
            max_ed_q   <= '0;
            max_muld_q <= '0;
            max_mulr_q <= '0;
        end else if (s2_vld_q) begin
            err_cnt_q <= err_cnt_q + CNT_W'(s2_err_q);
            sum_ed_q  <= sum_ed_q + SW'(s2_ed_q);
            if (s2_ed_q > max_ed_q) begin
                max_ed_q   <= s2_ed_q;
                max_muld_q <= s2_muld_q;
                max_mulr_q <= s2_mulr_q;
            end
        end
    end

    assign in_rdy    = in_rdy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_cnt   = err_cnt_q;
    assign sum_ed    = sum_ed_q;
    assign max_ed    = max_ed_q;
    assign max_muld  = max_muld_q;
    assign max_mulr  = max_mulr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ap_mult_err_mon.sv
// Self-checking bench for ap_mult_err_mon: directed spec runs plus randomized
// runs checked against a list-based statistics model.
module tb_ap_mult_err_mon;

    localparam int DW    = 8;
    localparam int CNT_W = 16;
    localparam int PW    = 2 * DW;
    localparam int SW    = 2 * DW + CNT_W;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             in_vld = 1'b0;
    logic             in_rdy;
    logic [DW-1:0]    muld = '0;
    logic [DW-1:0]    mulr = '0;
    logic [PW-1:0]    res = '0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_cnt;
    logic [SW-1:0]    sum_ed;
    logic [PW-1:0]    max_ed;
    logic [DW-1:0]    max_muld;
    logic [DW-1:0]    max_mulr;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    ap_mult_err_mon #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_vld(in_vld), .in_rdy(in_rdy),
        .muld(muld), .mulr(mulr), .res(res),
        .busy(busy), .done(done),
        .err_cnt(err_cnt), .sum_ed(sum_ed), .max_ed(max_ed),
        .max_muld(max_muld), .max_mulr(max_mulr),
        .dbg_state(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    // Samples of the current run, and an optional in_vld pattern
    logic [DW-1:0] q_muld[$];
    logic [DW-1:0] q_mulr[$];
    logic [PW-1:0] q_res[$];
    int            pat_q[$];

    // Statistics captured in the done cycle, and cycles spent feeding
    logic [CNT_W-1:0] o_cnt;
    logic [SW-1:0]    o_sum;
    logic [PW-1:0]    o_max;
    logic [DW-1:0]    o_md, o_mr;
    int               g_cyc;

    // ---------------- reference model ----------------
    // Walks the sample list with plain integer arithmetic.
    task automatic model(output logic [CNT_W-1:0] e_cnt, output logic [SW-1:0] e_sum,
                         output logic [PW-1:0] e_max, output logic [DW-1:0] e_md,
                         output logic [DW-1:0] e_mr);
        int exact, r, ed, best;
        e_cnt = '0; e_sum = '0; e_max = '0; e_md = '0; e_mr = '0;
        best = 0;
        foreach (q_muld[i]) begin
            exact = int'(q_muld[i]) * int'(q_mulr[i]);
            r     = int'(q_res[i]);
            ed    = (exact > r) ? exact - r : r - exact;
            if (ed != 0) e_cnt = e_cnt + 1'b1;
            e_sum = e_sum + SW'(ed);
            if (ed > best) begin
                best  = ed;
                e_max = PW'(ed);
                e_md  = q_muld[i];
                e_mr  = q_mulr[i];
            end
        end
    endtask

    task automatic clear_samples();
        q_muld.delete(); q_mulr.delete(); q_res.delete(); pat_q.delete();
    endtask

    task automatic add_sample(input int a, input int b, input int r);
        q_muld.push_back(DW'(a)); q_mulr.push_back(DW'(b)); q_res.push_back(PW'(r));
    endtask

    // ---------------- driver: one full run ----------------
    // Starts a run of q_muld.size() samples, feeds them with gaps (from pat_q
    // or random), checks the handshake and done timing, and checks the final
    // statistics against the model. With extra=1, in_vld stays high with a
    // large-error sample after the last transfer; it must not be accepted.
    task automatic run_case(input string name, input int gap_pct, input bit extra);
        int n, sent, v;
        logic [CNT_W-1:0] e_cnt;
        logic [SW-1:0]    e_sum;
        logic [PW-1:0]    e_max;
        logic [DW-1:0]    e_md, e_mr;
        n = q_muld.size();
        model(e_cnt, e_sum, e_max, e_md, e_mr);
        @(negedge clk);
        start = 1'b1; len = CNT_W'(n); in_vld = 1'b0;
        @(negedge clk);
        start = 1'b0; len = CNT_W'($urandom_range(0, 65535));
        sent = 0; g_cyc = 0;
        if (n == 0) begin
            n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL %s len0_done: got %b exp 1", name, done); end
            n_cmp++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL %s len0_in_rdy: got %b exp 0", name, in_rdy); end
            o_cnt = err_cnt; o_sum = sum_ed; o_max = max_ed; o_md = max_muld; o_mr = max_mulr;
            @(negedge clk);
            n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s len0_done_pulse: got %b exp 0", name, done); end
            n_cmp++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL %s len0_in_rdy_after: got %b exp 0", name, in_rdy); end
        end else begin
            while (sent < n && g_cyc < 2000) begin
                n_cmp++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL %s in_rdy_run: got %b exp 1 (sent %0d)", name, in_rdy, sent); end
                n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_early: got %b exp 0", name, done); end
                if (pat_q.size() > 0) v = pat_q.pop_front();
                else v = ($urandom_range(0, 99) >= gap_pct) ? 1 : 0;
                in_vld = v[0];
                if (v != 0) begin
                    muld = q_muld[sent]; mulr = q_mulr[sent]; res = q_res[sent];
                end else begin
                    muld = DW'($urandom); mulr = DW'($urandom); res = PW'($urandom);
                end
                @(posedge clk);
                if (v != 0) sent++;
                g_cyc++;
                @(negedge clk);
            end
            n_cmp++; if (sent != n) begin n_fail++; $display("FAIL %s feed_timeout: sent %0d exp %0d", name, sent, n); end
            // Now one half cycle after the last transfer edge t.
            in_vld = extra; muld = 8'd255; mulr = 8'd255; res = '0;
            for (int k = 1; k <= 3; k++) begin
                n_cmp++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL %s in_rdy_drain k=%0d: got %b exp 0", name, k, in_rdy); end
                n_cmp++; if (busy !== (k < 3)) begin n_fail++; $display("FAIL %s busy k=%0d: got %b exp %b", name, k, busy, k < 3); end
                n_cmp++; if (done !== (k == 3)) begin n_fail++; $display("FAIL %s done_timing k=%0d: got %b exp %b", name, k, done, k == 3); end
                if (k == 3) begin
                    o_cnt = err_cnt; o_sum = sum_ed; o_max = max_ed; o_md = max_muld; o_mr = max_mulr;
                end
                @(negedge clk);
            end
            n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_pulse_width: got %b exp 0", name, done); end
            n_cmp++; if (err_cnt !== o_cnt) begin n_fail++; $display("FAIL %s idle_hold err_cnt: got %0d exp %0d", name, err_cnt, o_cnt); end
            in_vld = 1'b0;
        end
        n_cmp++; if (o_cnt !== e_cnt) begin n_fail++; $display("FAIL %s err_cnt: got %0d exp %0d", name, o_cnt, e_cnt); end
        n_cmp++; if (o_sum !== e_sum) begin n_fail++; $display("FAIL %s sum_ed: got %0d exp %0d", name, o_sum, e_sum); end
        n_cmp++; if (o_max !== e_max) begin n_fail++; $display("FAIL %s max_ed: got %0d exp %0d", name, o_max, e_max); end
        n_cmp++; if (o_md !== e_md) begin n_fail++; $display("FAIL %s max_muld: got %0d exp %0d", name, o_md, e_md); end
        n_cmp++; if (o_mr !== e_mr) begin n_fail++; $display("FAIL %s max_mulr: got %0d exp %0d", name, o_mr, e_mr); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL reset in_rdy: got %b exp 0", in_rdy); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b exp 0", done); end
        n_cmp++; if (err_cnt !== '0) begin n_fail++; $display("FAIL reset err_cnt: got %0d exp 0", err_cnt); end
        n_cmp++; if (sum_ed !== '0) begin n_fail++; $display("FAIL reset sum_ed: got %0d exp 0", sum_ed); end
        n_cmp++; if (max_ed !== '0) begin n_fail++; $display("FAIL reset max_ed: got %0d exp 0", max_ed); end
        n_cmp++; if (max_muld !== '0) begin n_fail++; $display("FAIL reset max_muld: got %0d exp 0", max_muld); end
        n_cmp++; if (max_mulr !== '0) begin n_fail++; $display("FAIL reset max_mulr: got %0d exp 0", max_mulr); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_release in_rdy: got %b exp 0", in_rdy); end
    endtask

    task automatic test_exact();
        clear_samples();
        add_sample(3, 5, 15); add_sample(255, 255, 65025);
        add_sample(16, 16, 256); add_sample(200, 100, 20000);
        run_case("exact", 0, 1'b0);
        n_cmp++; if (o_cnt !== 16'd0 || o_sum !== 32'd0 || o_max !== 16'd0) begin
            n_fail++; $display("FAIL exact_const: got cnt %0d sum %0d max %0d exp 0 0 0", o_cnt, o_sum, o_max);
        end
    endtask

    task automatic test_error();
        clear_samples();
        add_sample(3, 5, 14); add_sample(255, 255, 65025);
        add_sample(16, 16, 250); add_sample(200, 100, 20000);
        run_case("error", 0, 1'b0);
        n_cmp++; if (o_cnt !== 16'd2 || o_sum !== 32'd7 || o_max !== 16'd6 || o_md !== 8'd16 || o_mr !== 8'd16) begin
            n_fail++; $display("FAIL error_const: got %0d/%0d/%0d/%0d/%0d exp 2/7/6/16/16", o_cnt, o_sum, o_max, o_md, o_mr);
        end
    endtask

    task automatic test_over_tie();
        clear_samples();
        add_sample(2, 2, 10); add_sample(3, 3, 3); add_sample(1, 1, 1);
        run_case("over_tie", 0, 1'b0);
        n_cmp++; if (o_cnt !== 16'd2 || o_sum !== 32'd12 || o_max !== 16'd6 || o_md !== 8'd2 || o_mr !== 8'd2) begin
            n_fail++; $display("FAIL over_tie_const: got %0d/%0d/%0d/%0d/%0d exp 2/12/6/2/2", o_cnt, o_sum, o_max, o_md, o_mr);
        end
    endtask

    task automatic test_back_to_back();
        clear_samples();
        add_sample(7, 9, 60); add_sample(12, 12, 150); add_sample(100, 3, 300);
        pat_q = '{1, 0, 0, 1, 1};
        run_case("b2b", 0, 1'b1);
        n_cmp++; if (g_cyc != 5) begin n_fail++; $display("FAIL b2b_cycles: got %0d exp 5", g_cyc); end
        n_cmp++; if (o_cnt !== 16'd2 || o_sum !== 32'd9) begin
            n_fail++; $display("FAIL b2b_const: got cnt %0d sum %0d exp 2 9", o_cnt, o_sum);
        end
    endtask

    task automatic test_len_zero();
        clear_samples();
        run_case("len0", 0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        @(negedge clk);
        start = 1'b1; len = 16'd5;
        @(negedge clk);
        start = 1'b0;
        in_vld = 1'b1; muld = 8'd3; mulr = 8'd5; res = 16'd14;
        @(negedge clk);
        muld = 8'd2; mulr = 8'd2; res = 16'd10;
        @(negedge clk);
        in_vld = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (err_cnt !== 16'd2 || busy !== 1'b1) begin
            n_fail++; $display("FAIL midrun_pre: got cnt %0d busy %b exp 2 1", err_cnt, busy);
        end
        rst = 1'b1;
        #1;
        n_cmp++; if (err_cnt !== '0 || sum_ed !== '0 || max_ed !== '0 || max_muld !== '0 || max_mulr !== '0) begin
            n_fail++; $display("FAIL midrun_stats_clear: got %0d/%0d/%0d/%0d/%0d exp 0", err_cnt, sum_ed, max_ed, max_muld, max_mulr);
        end
        n_cmp++; if (in_rdy !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL midrun_flags_clear: got rdy %b busy %b done %b exp 0", in_rdy, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        n_cmp++; if (seen_done != 0) begin n_fail++; $display("FAIL midrun_no_done: got %0d active cycles exp 0", seen_done); end
        clear_samples();
        add_sample(9, 9, 90);
        run_case("after_reset", 0, 1'b0);
    endtask

    task automatic test_random();
        int n, exact, d, r;
        for (int run = 0; run < 8; run++) begin
            clear_samples();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                muld = DW'($urandom); mulr = DW'($urandom);
                exact = int'(muld) * int'(mulr);
                case ($urandom_range(0, 3))
                    0, 1: r = exact;
                    2: begin
                        d = $urandom_range(1, 6);
                        r = ($urandom_range(0, 1) != 0) ? exact + d : exact - d;
                        if (r < 0) r = 0;
                    end
                    default: r = $urandom_range(0, 65535);
                endcase
                add_sample(int'(muld), int'(mulr), r);
            end
            run_case($sformatf("rand%0d", run), 35, run[0]);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_exact();
        test_error();
        test_len_zero();
        test_over_tie();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ap_mult_err_mon.md
Name: ap_mult_err_mon

Overview:
Pipelined error-statistics monitor placed directly downstream of the 8-bit approximate unsigned Wallace multiplier.
- Each accepted sample carries the operand pair and the multiplier's approximate product.
- The block recomputes the exact product internally and accumulates error statistics over a run of `len` samples: error count, sum of error distance, and maximum error distance with the operands that produced it.
- Used in hardware evaluation of evolved approximate multipliers.

Parameters:
DW, 8, operand width; product width is 2*DW
CNT_W, 16, width of the sample-length counter and of err_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  run request, sampled only in IDLE
len  in  CNT_W  number of samples in the run, captured on start
in_vld  in  1  sample valid
in_rdy  out  1  sample ready
muld  in  DW  multiplicand of the sample
mulr  in  DW  multiplier of the sample
res  in  2*DW  approximate product for (muld, mulr)
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse; statistics final
err_cnt  out  CNT_W  count of samples with res != muld*mulr
sum_ed  out  2*DW+CNT_W  sum of |muld*mulr - res|
max_ed  out  2*DW  largest error distance in the run
max_muld  out  DW  muld of the first sample reaching max_ed
max_mulr  out  DW  mulr of the first sample reaching max_ed

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: state=IDLE, pipeline valids=0. All outputs are 0: in_rdy, busy, done, err_cnt, sum_ed, max_ed, max_muld, max_mulr.
- Handshake: a sample transfers on a rising edge with in_vld&in_rdy. in_rdy=1 only in RUN. Inputs are ignored while in_rdy=0.
- Pipeline, for a transfer at edge t:
  - S1 registers at edge t: muld, mulr, res, exact=muld*mulr (unsigned, 2*DW bits), and a valid bit.
  - S2 registers at edge t+1: ed=|exact-res| (absolute, so overestimates count), err=(ed!=0), operands, valid.
  - S3 updates statistics at edge t+2.
  - One sample per cycle at full throughput; bubbles when in_vld=0 are allowed.
- Statistics update on S2 valid:
  - err_cnt += err.
  - sum_ed += ed (zero-extended). The width guarantees no overflow for len <= 2^CNT_W-1, so there is no saturation.
  - If ed > max_ed (strictly greater), load max_ed=ed, max_muld, max_mulr. Ties keep the earliest sample.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE:
    - start & len!=0: clear all statistics, load remaining=len, go to RUN.
    - start & len==0: clear statistics, go to DONE.
    - Otherwise stay. Statistics hold their last values.
  - RUN: each transfer decrements remaining. The transfer with remaining==1 goes to DRAIN.
  - DRAIN: in_rdy=0. Stay 2 cycles so the last sample reaches S3, then go to DONE. The last statistics update and the DONE entry occur on the same edge.
  - DONE: done=1 for exactly one cycle with final statistics visible, then go to IDLE.
- Timing: done is high in the cycle after edge t+2, where t is the last transfer edge. For len==0, done is high in the cycle after the start edge.
- start outside IDLE is ignored. len is only sampled with start.
- Reset mid-run: all state clears immediately, in-flight samples are dropped, and no done pulse is generated.

Test Plan:
- Exact run: len=4 with res=muld*mulr for (3,5),(255,255),(16,16),(200,100) -> done once; err_cnt=0, sum_ed=0, max_ed=0, max_muld=0, max_mulr=0.
- Error run: len=4, samples (3,5,res=14),(255,255,res=65025),(16,16,res=250),(200,100,res=20000) -> err_cnt=2, sum_ed=7, max_ed=6, max_muld=16, max_mulr=16.
- Overestimate and tie: len=3, samples (2,2,res=10),(3,3,res=3),(1,1,res=1) -> ed=6, 6, 0. Expect err_cnt=2, sum_ed=12, max_ed=6, max_muld=2, max_mulr=2 (first sample wins the tie).
- Back-to-back with backpressure gaps: len=3, in_vld pattern 1,0,0,1,1 -> exactly 3 transfers, in_rdy drops after the 3rd, done 3 cycles after the last transfer edge. A 4th in_vld is not accepted.
- len=0: start -> done high in the next cycle, statistics 0, in_rdy never asserted.
- Reset mid-RUN after 2 of 5 samples: rst pulse -> outputs return to 0, IDLE, no done. A new start with len=1 then completes normally.
